// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the serial boot loader.
// Holds the frame FSM enum, the UART receiver enum, sync byte and rw codes.
// Optional macro PROG_LOADER_CHECKSUM_EN adds the CSUM frame state.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // RAM rw encoding
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [2:0] {
        SYNC,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        DONE,
        ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        CSUM
`endif
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: RAM write port driven by the loader.
// addr/mem_in: word address and data; rw: write strobe (1 = WRITE).
interface prog_loader_if;
    logic [15:0] addr;
    logic [15:0] mem_in;
    logic        rw;

    modport master (output addr, mem_in, rw);
    modport slave  (input  addr, mem_in, rw);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchronizer and bit timer.
// Ports: clk, rst (sync, active high), rx in; data, byte_valid, framing_err out.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       framing_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_q;
    rx_state_t     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_q    <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_q    <= rx_sync;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_q && !rx_sync)
                    st_d = RX_START;
            end
            RX_START: begin
                // Mid-start re-check rejects glitches
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7)
                        st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Return to idle at stop midpoint so a
                // back-to-back start edge is not missed
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    st_d    = RX_IDLE;
                    valid_d = 1'b1;
                    ferr_d  = !rx_sync;
                    data_d  = shift_q;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign data        = data_q;
    assign byte_valid  = valid_q;
    assign framing_err = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART boot loader writing a program image into RAM.
// Ports: clk, rst, rx in; bus (addr/mem_in/rw) out; cpu_hold, done, err out.
// Macro PROG_LOADER_CHECKSUM_EN enables the trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_SIZE     = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    prog_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t FIN_ST = CSUM;
`else
    localparam state_t FIN_ST = DONE;
`endif

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .framing_err(rx_ferr)
    );

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] k_q, k_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] mem_in_q, mem_in_d;
    logic        rw_q, rw_d;
    logic [15:0] n;
    logic        last;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SYNC;
            len_hi_q <= '0;
            len_q    <= '0;
            hi_q     <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            mem_in_q <= '0;
            rw_q     <= READ;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            mem_in_q <= mem_in_d;
            rw_q     <= rw_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        hi_d     = hi_q;
        k_d      = k_q;
        addr_d   = addr_q;
        mem_in_d = mem_in_q;
        rw_d     = READ;
        n        = {len_hi_q, rx_data};
        last     = (k_q == len_q - 16'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        if (rx_valid && state_q != SYNC)
            csum_d = csum_q ^ rx_data;
`endif
        if (rx_valid && state_q != DONE
            && state_q != ERR) begin
            if (rx_ferr) begin
                state_d = ERR;
            end else begin
                unique case (state_q)
                    SYNC: begin
                        if (rx_data == SYNC_BYTE)
                            state_d = LEN_HI;
                    end
                    LEN_HI: begin
                        len_hi_d = rx_data;
                        state_d  = LEN_LO;
                    end
                    LEN_LO: begin
                        len_d = n;
                        // Range check keeps k within MEM_SIZE
                        if (32'(n) > 32'(MEM_SIZE + 1))
                            state_d = ERR;
                        else if (n == 16'd0)
                            state_d = FIN_ST;
                        else
                            state_d = DATA_HI;
                    end
                    DATA_HI: begin
                        hi_d    = rx_data;
                        state_d = DATA_LO;
                    end
                    DATA_LO: begin
                        rw_d     = WRITE;
                        addr_d   = k_q;
                        mem_in_d = {hi_q, rx_data};
                        k_d      = k_q + 16'd1;
                        state_d  = last ? FIN_ST : DATA_HI;
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    CSUM: begin
                        state_d = (rx_data == csum_q)
                                ? DONE : ERR;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.addr   = addr_q;
    assign bus.mem_in = mem_in_q;
    assign bus.rw     = rw_q;
    assign cpu_hold   = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed, table-driven bench for prog_loader.
// Drives UART frames at CLKS_PER_BIT=4 and logs RAM writes.
module tb_prog_loader;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic cpu_hold, done, err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];

    prog_loader_if bus ();

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_SIZE    (255)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .bus     (bus),
        .cpu_hold(cpu_hold),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rw === 1'b1) begin
            wa.push_back(bus.addr);
            wd.push_back(bus.mem_in);
        end
    end

    typedef struct {
        int           nb;
        logic [95:0]  b;
        int           sidx;
        bit           csum;
        int           nw;
        logic [15:0]  a0, d0, a1, d1;
        logic         exp_done, exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] v,
                             input bit stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        if (!stop_ok) begin
            rx = 1'b1;
            tick(2 * CPB);
        end
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        wa.delete();
        wd.delete();
    endtask

    task automatic send_vec(input vec_t v);
        logic [7:0] c;
        logic [7:0] x;
        c = 8'h00;
        for (int i = 0; i < v.nb; i++) begin
            x = v.b[95 - 8 * i -: 8];
            send_byte(x, 1'b1);
            if (i > v.sidx)
                c = c ^ x;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (v.csum)
            send_byte(c, 1'b1);
`endif
        tick(20);
    endtask

    task automatic check_writes(input string nm,
                                input int nw,
                                input logic [15:0] a0,
                                input logic [15:0] d0,
                                input logic [15:0] a1,
                                input logic [15:0] d1);
        check({nm, ".nwr"}, wa.size(), nw);
        if (nw > 0) begin
            check({nm, ".a0"}, (wa.size() > 0) ? wa[0] : 'x, a0);
            check({nm, ".d0"}, (wd.size() > 0) ? wd[0] : 'x, d0);
        end
        if (nw > 1) begin
            check({nm, ".a1"}, (wa.size() > 1) ? wa[1] : 'x, a1);
            check({nm, ".d1"}, (wd.size() > 1) ? wd[1] : 'x, d1);
        end
    endtask

    task automatic check_flags(input string nm,
                               input logic ed,
                               input logic ee);
        check({nm, ".done"}, done, ed);
        check({nm, ".err"}, err, ee);
        check({nm, ".hold"}, cpu_hold, !ed);
    endtask

    initial begin
        vecs[0] = '{7, 96'hA5_00_02_12_34_AB_CD_00_00_00_00_00,
                    0, 1'b1, 2, 16'h0, 16'h1234,
                    16'h1, 16'hABCD, 1'b1, 1'b0};
        vecs[1] = '{7, 96'h00_FF_A5_00_01_BE_EF_00_00_00_00_00,
                    2, 1'b1, 1, 16'h0, 16'hBEEF,
                    16'h0, 16'h0, 1'b1, 1'b0};
        vecs[2] = '{8, 96'hA5_01_01_12_34_A5_00_01_00_00_00_00,
                    0, 1'b0, 0, 16'h0, 16'h0,
                    16'h0, 16'h0, 1'b0, 1'b1};
        vecs[3] = '{3, 96'hA5_00_00_00_00_00_00_00_00_00_00_00,
                    0, 1'b1, 0, 16'h0, 16'h0,
                    16'h0, 16'h0, 1'b1, 1'b0};
        vecs[4] = '{3, 96'hA5_FF_FF_00_00_00_00_00_00_00_00_00,
                    0, 1'b0, 0, 16'h0, 16'h0,
                    16'h0, 16'h0, 1'b0, 1'b1};

        do_reset();
        check("rst.addr", bus.addr, 16'h0);
        check("rst.mem_in", bus.mem_in, 16'h0);
        check("rst.rw", bus.rw, 1'b0);
        check_flags("rst", 1'b0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            send_vec(vecs[t]);
            check_writes($sformatf("vec%0d", t), vecs[t].nw,
                         vecs[t].a0, vecs[t].d0,
                         vecs[t].a1, vecs[t].d1);
            check_flags($sformatf("vec%0d", t),
                        vecs[t].exp_done, vecs[t].exp_err);
        end

        // Bad stop bit on the second data byte
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        tick(20);
        check_writes("ferr", 0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_flags("ferr", 1'b0, 1'b1);
        do_reset();
        send_vec(vecs[0]);
        check_writes("ferr_rl", 2, 16'h0, 16'h1234,
                     16'h1, 16'hABCD);
        check_flags("ferr_rl", 1'b1, 1'b0);

        // Reset between first and second word of N=3
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(10);
        check_writes("mid", 1, 16'h0, 16'h1122,
                     16'h0, 16'h0);
        rst = 1'b1;
        tick(2);
        check("mid.addr", bus.addr, 16'h0);
        check("mid.mem_in", bus.mem_in, 16'h0);
        check("mid.rw", bus.rw, 1'b0);
        check_flags("mid", 1'b0, 1'b0);
        rst = 1'b0;
        tick(2);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        tick(20);
        check("mid.nwr2", wa.size(), 1);
        check_flags("mid2", 1'b0, 1'b0);
        wa.delete();
        wd.delete();
        send_vec(vecs[0]);
        check_writes("mid_rl", 2, 16'h0, 16'h1234,
                     16'h1, 16'hABCD);
        check_flags("mid_rl", 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum: word still written, then error
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(20);
        check_writes("csum", 1, 16'h0, 16'h1234,
                     16'h0, 16'h0);
        check_flags("csum", 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
